uart_mem_bridge: RTL and testbench
==================================

Name: uart_mem_bridge

Overview:
- Sits directly downstream of the UART multi-byte packet receiver.
- Consumes each decoded packet: target address, memory type, read/write flag and 32-bit payload.
- Write packets: performs a single-cycle write into instruction or data memory, then returns an ACK byte over UART TX.
- Read packets: fetches the addressed word and returns it as 4 UART bytes, MSB first. Provides the host-side load/inspect path for the pipeline CPU's memories.

Parameters:
- CLKS_PER_BIT, 87, clk cycles per UART bit on TX (10 MHz / 115200).
- ACK_BYTE, 8'hAC, byte returned after a completed write.
- ADDR_BITS, 9, memory word-address width.

Ports:
- clk  input  1  system clock
- reset  input  1  async active-high reset
- pkt_valid  input  1  one-cycle strobe, packet fields valid
- pkt_data  input  32  write payload (ignored for reads)
- pkt_addr  input  ADDR_BITS  target word address
- pkt_mem_type  input  1  0 = instruction memory, 1 = data memory
- pkt_rw  input  1  1 = write, 0 = read
- imem_we  output  1  instruction memory write strobe
- dmem_we  output  1  data memory write strobe
- mem_re  output  1  read request (both memories, one cycle)
- mem_addr  output  ADDR_BITS  memory address
- mem_wdata  output  32  memory write data
- imem_rdata  input  32  instruction memory read data, valid 1 cycle after mem_re
- dmem_rdata  input  32  data memory read data, valid 1 cycle after mem_re
- tx  output  1  UART TX pin, idle high
- busy  output  1  high whenever state != IDLE
- overrun  output  1  sticky: a packet arrived while busy

Behaviour:
- Reset values:
  - tx=1; all strobes 0; mem_addr=0; mem_wdata=0; busy=0; overrun=0.
  - State=IDLE; internal byte index=0.
- Reset mid-operation aborts immediately; tx returns high. A partially sent frame is truncated; the host must tolerate this.
- Packet capture:
  - In IDLE, pkt_valid registers addr, type, rw and data on that edge.
  - The next state is WRITE if rw=1, otherwise READ.
- pkt_valid while not IDLE: packet dropped, overrun set to 1. Overrun clears only on reset.
- WRITE (1 cycle):
  - Asserts imem_we if type=0, else dmem_we.
  - mem_addr and mem_wdata driven with the captured values.
  - Next state TX_LOAD; tx byte = ACK_BYTE; byte count = 1.
- READ (1 cycle): mem_re=1 with mem_addr. Next state READ_WAIT.
- READ_WAIT (1 cycle):
  - Captures imem_rdata or dmem_rdata, selected by the captured type, into a 32-bit shift register.
  - Byte count = 4. Next state TX_LOAD.
- TX_LOAD:
  - Issues a 1-cycle start to the TX sub-module with the current byte: bits [31:24] of the shift register, or ACK_BYTE.
  - Next state TX_WAIT.
- TX_WAIT: waits for TX done, then:
  - Shifts the register left by 8 and decrements the count.
  - count==0 → IDLE, else → TX_LOAD.
- Frame format: 8N1, LSB first. Start bit low, 8 data bits, stop bit high, each exactly CLKS_PER_BIT clocks.
- Back-to-back bytes: the next start bit begins 1 clk after the previous stop bit ends (TX_LOAD cycle).
- Latency:
  - Write strobe occurs 1 clk after pkt_valid.
  - Read: ACK/first start bit falls 3 clks after pkt_valid (WRITE/READ_WAIT → TX_LOAD → start).
  - Write: first start bit falls 2 clks after pkt_valid.
- Strobes (imem_we, dmem_we, mem_re) are never asserted together and are never asserted outside WRITE/READ.
- mem_addr holds its last value between operations; no glitching required.
- Edge addresses 0 and 511 behave identically; there is no wrap logic.

Decomposition:
- Shared package, uart_pkg:
  - Bridge state enum (IDLE, WRITE, READ, READ_WAIT, TX_LOAD, TX_WAIT).
  - Memory-type constants MEM_INSTR=0, MEM_DATA=1.
  - RW constants RW_READ=0, RW_WRITE=1.
  - Default ACK byte.
- Sub-module uart_bits_tx, parameter CLKS_PER_BIT:
  - Ports: clk, reset, start, data[7:0], tx, busy, done.
  - done is a 1-cycle pulse at the end of the stop bit.
  - The TX counterpart of the existing bit-level receiver; reusable elsewhere.

Test Plan:
- Write imem: pkt_valid, rw=1, type=0, addr=9'h005, data=32'hDEADBEEF → imem_we high exactly 1 clk with mem_addr=5, mem_wdata=DEADBEEF; dmem_we stays 0; tx emits 0xAC (line sequence 0,0,0,1,1,0,1,0,1,1); busy falls after the stop bit.
- Read dmem: preload dmem_rdata model addr 9'h1FF=32'h12345678; rw=0, type=1 → mem_re 1 clk; tx emits bytes 0x12,0x34,0x56,0x78 in order; each frame is 10×CLKS_PER_BIT clks; 1 clk gap between frames.
- Memory select: read type=0 with imem=32'hA5A5_0001, dmem=32'hFFFF_FFFF → transmitted bytes A5,A5,00,01.
- Overrun: second pkt_valid issued during the read's TX → no extra strobes; overrun=1; output stream identical to the single-read case.
- Reset mid-TX: assert reset during byte 2 of a read → tx=1, busy=0 immediately; a fresh write packet afterwards behaves as in scenario 1.
- Timing: with CLKS_PER_BIT=4, write packet → start bit falls 2 clks after pkt_valid; busy deasserts exactly 42 clks after pkt_valid (2 clk to start bit + 40 clk frame).

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART host-access blocks.
// Holds the bridge state encoding, the memory-type and read/write flag
// values carried in decoded packets, and the default write-acknowledge byte.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITE     = 3'd1,
    READ      = 3'd2,
    READ_WAIT = 3'd3,
    TX_LOAD   = 3'd4,
    TX_WAIT   = 3'd5
  } bridge_state_t;

  localparam logic MEM_INSTR = 1'b0;
  localparam logic MEM_DATA  = 1'b1;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam logic [7:0] DEFAULT_ACK_BYTE = 8'hAC;

endpackage

// File: rtl/uart_bits_tx.sv
// Bit-level UART transmitter, 8N1, LSB first.
// Ports:
//   clk, reset   - system clock, async active-high reset
//   start        - 1-cycle request; accepted only while not busy
//   data[7:0]    - byte to send, sampled with start
//   tx           - serial line, idle high
//   busy         - high from the start bit until the stop bit ends
//   done         - 1-cycle pulse during the last clock of the stop bit
// Every bit (start, 8 data, stop) lasts exactly CLKS_PER_BIT clocks.
module uart_bits_tx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] clk_cnt;
  logic [3:0]    bit_idx;  // 0 = start bit, 1..8 = data bits, 9 = stop bit
  logic [7:0]    shifter;
  logic          active;
  logic          bit_end;

  assign bit_end = active && (clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign busy    = active;
  assign done    = bit_end && (bit_idx == 4'd9);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx      <= 1'b1;
      active  <= 1'b0;
      clk_cnt <= '0;
      bit_idx <= '0;
      shifter <= '0;
    end else if (!active) begin
      if (start) begin
        active  <= 1'b1;
        tx      <= 1'b0;
        shifter <= data;
        clk_cnt <= '0;
        bit_idx <= '0;
      end
    end else if (bit_end) begin
      clk_cnt <= '0;
      if (bit_idx == 4'd9) begin
        active <= 1'b0;  // line is already high from the stop bit
      end else begin
        bit_idx <= bit_idx + 4'd1;
        if (bit_idx == 4'd8) begin
          tx <= 1'b1;
        end else begin
          tx      <= shifter[0];
          shifter <= {1'b0, shifter[7:1]};
        end
      end
    end else begin
      clk_cnt <= clk_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_mem_bridge.sv
// Bridge from decoded UART packets to the CPU's instruction/data memories.
// Writes perform a single-cycle strobe and answer with ACK_BYTE; reads fetch
// one word and answer with its four bytes, MSB first.
// Ports:
//   clk, reset                - system clock, async active-high reset
//   pkt_valid/data/addr/      - decoded packet, fields valid on pkt_valid
//   pkt_mem_type/pkt_rw
//   imem_we, dmem_we, mem_re  - 1-cycle memory strobes
//   mem_addr, mem_wdata       - memory address / write data (held)
//   imem_rdata, dmem_rdata    - read data, valid 1 cycle after mem_re
//   tx                        - UART TX line, idle high
//   busy                      - high whenever the bridge is not idle
//   overrun                   - sticky, a packet arrived while busy
// Handshake: pkt_valid is a single-cycle strobe with no ready; the bridge
// takes it only in IDLE and otherwise drops the packet and flags overrun.
module uart_mem_bridge
  import uart_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 87,
  parameter logic [7:0] ACK_BYTE     = DEFAULT_ACK_BYTE,
  parameter int         ADDR_BITS    = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pkt_valid,
  input  logic [31:0]          pkt_data,
  input  logic [ADDR_BITS-1:0] pkt_addr,
  input  logic                 pkt_mem_type,
  input  logic                 pkt_rw,
  output logic                 imem_we,
  output logic                 dmem_we,
  output logic                 mem_re,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          imem_rdata,
  input  logic [31:0]          dmem_rdata,
  output logic                 tx,
  output logic                 busy,
  output logic                 overrun
);

  bridge_state_t state;
  logic          mem_type_q;
  logic [31:0]   shreg;     // outgoing bytes, current byte in [31:24]
  logic [2:0]    byte_cnt;  // bytes still to send
  logic          tx_start;
  logic          tx_busy;
  logic          tx_done;

  assign tx_start = (state == TX_LOAD);
  assign busy     = (state != IDLE);

  uart_bits_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk   (clk),
    .reset (reset),
    .start (tx_start),
    .data  (shreg[31:24]),
    .tx    (tx),
    .busy  (tx_busy),
    .done  (tx_done)
  );

  // Strobes are set on entry to WRITE/READ so they are high exactly for the
  // one cycle the FSM spends in that state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      imem_we    <= 1'b0;
      dmem_we    <= 1'b0;
      mem_re     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      overrun    <= 1'b0;
      mem_type_q <= MEM_INSTR;
      shreg      <= '0;
      byte_cnt   <= '0;
    end else begin
      if (pkt_valid && (state != IDLE)) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (pkt_valid) begin
            mem_addr   <= pkt_addr;
            mem_wdata  <= pkt_data;
            mem_type_q <= pkt_mem_type;
            if (pkt_rw == RW_WRITE) begin
              imem_we <= (pkt_mem_type == MEM_INSTR);
              dmem_we <= (pkt_mem_type == MEM_DATA);
              state   <= WRITE;
            end else begin
              mem_re <= 1'b1;
              state  <= READ;
            end
          end
        end
        WRITE: begin
          imem_we  <= 1'b0;
          dmem_we  <= 1'b0;
          shreg    <= {ACK_BYTE, 24'h0};
          byte_cnt <= 3'd1;
          state    <= TX_LOAD;
        end
        READ: begin
          mem_re <= 1'b0;
          state  <= READ_WAIT;
        end
        READ_WAIT: begin
          shreg    <= (mem_type_q == MEM_DATA) ? dmem_rdata : imem_rdata;
          byte_cnt <= 3'd4;
          state    <= TX_LOAD;
        end
        TX_LOAD: begin
          // The transmitter has always finished its frame by now; the check
          // only guards against a start being ignored.
          if (!tx_busy) state <= TX_WAIT;
        end
        TX_WAIT: begin
          if (tx_done) begin
            shreg    <= {shreg[23:0], 8'h00};
            byte_cnt <= byte_cnt - 3'd1;
            state    <= (byte_cnt == 3'd1) ? IDLE : TX_LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Self-checking bench for uart_mem_bridge (CLKS_PER_BIT = 4).
module tb_uart_mem_bridge;

  localparam int         CPB   = 4;
  localparam int         AW    = 9;
  localparam logic [7:0] ACK   = 8'hAC;
  localparam int         FRAME = 10 * CPB;

  typedef struct packed {
    logic [31:0] cyc;
    logic        i_we;
    logic        d_we;
    logic        re;
    logic [8:0]  addr;
    logic [31:0] wdata;
  } strobe_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          pkt_valid;
  logic [31:0]   pkt_data;
  logic [AW-1:0] pkt_addr;
  logic          pkt_mem_type;
  logic          pkt_rw;
  logic          imem_we, dmem_we, mem_re;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   imem_rdata = '0;
  logic [31:0]   dmem_rdata = '0;
  logic          tx, busy, overrun;

  logic [31:0] cycle = '0;
  int          checks = 0;
  int          errors = 0;

  logic [7:0]  rx_q[$];
  logic [31:0] start_q[$];
  strobe_t     strobe_q[$];
  logic [7:0]  exp_q[$];

  logic [31:0] env_imem[512];
  logic [31:0] env_dmem[512];
  logic [31:0] ref_imem[512];
  logic [31:0] ref_dmem[512];

  uart_mem_bridge #(
    .CLKS_PER_BIT(CPB),
    .ACK_BYTE    (ACK),
    .ADDR_BITS   (AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pkt_valid   (pkt_valid),
    .pkt_data    (pkt_data),
    .pkt_addr    (pkt_addr),
    .pkt_mem_type(pkt_mem_type),
    .pkt_rw      (pkt_rw),
    .imem_we     (imem_we),
    .dmem_we     (dmem_we),
    .mem_re      (mem_re),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .imem_rdata  (imem_rdata),
    .dmem_rdata  (dmem_rdata),
    .tx          (tx),
    .busy        (busy),
    .overrun     (overrun)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [31:0] init_word(int i, bit d);
    return (32'(i) * 32'h9E37_79B1) ^ (d ? 32'h5A5A_0F0F : 32'h0123_4567);
  endfunction

  // ---------------- memory environment ----------------
  // Read data is valid only in the cycle after mem_re; otherwise it is noise.
  initial begin
    for (int i = 0; i < 512; i++) begin
      env_imem[i] = init_word(i, 1'b0);
      env_dmem[i] = init_word(i, 1'b1);
    end
    forever begin
      @(posedge clk);
      if (imem_we) env_imem[mem_addr] <= mem_wdata;
      if (dmem_we) env_dmem[mem_addr] <= mem_wdata;
      if (mem_re) begin
        imem_rdata <= env_imem[mem_addr];
        dmem_rdata <= env_dmem[mem_addr];
      end else begin
        imem_rdata <= $urandom;
        dmem_rdata <= $urandom;
      end
    end
  end

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (imem_we || dmem_we || mem_re)
      strobe_q.push_back('{cycle, imem_we, dmem_we, mem_re, mem_addr, mem_wdata});
  end

  // UART receiver: samples each bit in its middle.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge tx);
      #1;
      start_q.push_back(cycle);
      repeat (CPB / 2) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        repeat (CPB) @(negedge clk);
        b[k] = tx;
      end
      repeat (CPB) @(negedge clk);
      rx_q.push_back(b);
    end
  end

  // ---------------- driver / model tasks ----------------
  task automatic clear_logs();
    rx_q.delete();
    start_q.delete();
    strobe_q.delete();
  endtask

  task automatic send_pkt(input logic rw, input logic typ, input logic [AW-1:0] addr,
                          input logic [31:0] data, output logic [31:0] e0);
    @(negedge clk);
    pkt_rw       = rw;
    pkt_mem_type = typ;
    pkt_addr     = addr;
    pkt_data     = data;
    pkt_valid    = 1'b1;
    @(posedge clk);
    #1;
    pkt_valid = 1'b0;
    e0        = cycle;
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok, output logic [31:0] fall);
    ok   = 1'b0;
    fall = '0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok   = 1'b1;
        fall = cycle;
        break;
      end
    end
  endtask

  // Reference: a write lands in the addressed memory and answers ACK;
  // a read answers the stored word, most significant byte first.
  task automatic model_expect(input logic rw, input logic typ, input logic [AW-1:0] addr,
                              input logic [31:0] data);
    logic [31:0] word;
    exp_q.delete();
    if (rw) begin
      if (typ) ref_dmem[addr] = data;
      else     ref_imem[addr] = data;
      exp_q.push_back(ACK);
    end else begin
      word = typ ? ref_dmem[addr] : ref_imem[addr];
      for (int k = 0; k < 4; k++) exp_q.push_back(8'((word >> (24 - 8 * k)) & 32'hFF));
    end
  endtask

  task automatic preload(input logic typ, input logic [AW-1:0] addr, input logic [31:0] data);
    logic [31:0] e0, fall;
    bit ok;
    model_expect(1'b1, typ, addr, data);
    send_pkt(1'b1, typ, addr, data, e0);
    wait_idle(400, ok, fall);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL preload_idle busy=%b want 0 within 400 clks", busy);
    end
    clear_logs();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++;
    if ({tx, busy, overrun} !== 3'b100) begin
      errors++;
      $display("FAIL reset_tx_busy_ovr got %b want 100", {tx, busy, overrun});
    end
    checks++;
    if ({imem_we, dmem_we, mem_re} !== 3'b000) begin
      errors++;
      $display("FAIL reset_strobes got %b want 000", {imem_we, dmem_we, mem_re});
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_addr_wdata got %h/%h want 0/0", mem_addr, mem_wdata);
    end
  endtask

  task automatic test_write_imem(input string tag);
    logic [31:0] e0, fall;
    bit ok;
    clear_logs();
    model_expect(1'b1, 1'b0, 9'h005, 32'hDEAD_BEEF);
    send_pkt(1'b1, 1'b0, 9'h005, 32'hDEAD_BEEF, e0);
    wait_idle(400, ok, fall);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_idle timeout", tag);
    end
    checks++;
    if (strobe_q.size() != 1) begin
      errors++;
      $display("FAIL %s_strobe_count got %0d want 1", tag, strobe_q.size());
    end else begin
      checks++;
      if ({strobe_q[0].i_we, strobe_q[0].d_we, strobe_q[0].re} !== 3'b100 || strobe_q[0].cyc !== e0) begin
        errors++;
        $display("FAIL %s_strobe kind %b at %0d want 100 at %0d", tag,
                 {strobe_q[0].i_we, strobe_q[0].d_we, strobe_q[0].re}, strobe_q[0].cyc, e0);
      end
      checks++;
      if (strobe_q[0].addr !== 9'h005 || strobe_q[0].wdata !== 32'hDEAD_BEEF) begin
        errors++;
        $display("FAIL %s_addr_data got %h/%h want 005/deadbeef", tag,
                 strobe_q[0].addr, strobe_q[0].wdata);
      end
    end
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hAC) begin
      errors++;
      $display("FAIL %s_ack got %0d bytes first %h want 1 byte ac", tag, rx_q.size(),
               (rx_q.size() > 0) ? rx_q[0] : 8'h00);
    end
    checks++;
    if (start_q.size() < 1 || start_q[0] !== e0 + 2) begin
      errors++;
      $display("FAIL %s_start_latency got %0d want %0d", tag,
               (start_q.size() > 0) ? start_q[0] : 0, e0 + 2);
    end
    checks++;
    if (fall !== e0 + 2 + FRAME) begin
      errors++;
      $display("FAIL %s_busy_fall got %0d want %0d", tag, fall, e0 + 2 + FRAME);
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL %s_overrun got %b want 0", tag, overrun);
    end
  endtask

  task automatic test_read_dmem();
    logic [31:0] e0, fall;
    bit ok;
    preload(1'b1, 9'h1FF, 32'h1234_5678);
    exp_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    send_pkt(1'b0, 1'b1, 9'h1FF, $urandom, e0);
    wait_idle(400, ok, fall);
    checks++;
    if (!ok || strobe_q.size() != 1) begin
      errors++;
      $display("FAIL read_strobe idle=%b count=%0d want 1/1", ok, strobe_q.size());
    end else begin
      checks++;
      if ({strobe_q[0].i_we, strobe_q[0].d_we, strobe_q[0].re} !== 3'b001 ||
          strobe_q[0].cyc !== e0 || strobe_q[0].addr !== 9'h1FF) begin
        errors++;
        $display("FAIL read_re kind %b at %0d addr %h want 001 at %0d addr 1ff",
                 {strobe_q[0].i_we, strobe_q[0].d_we, strobe_q[0].re}, strobe_q[0].cyc,
                 strobe_q[0].addr, e0);
      end
    end
    checks++;
    if (rx_q.size() != 4) begin
      errors++;
      $display("FAIL read_bytes_count got %0d want 4", rx_q.size());
    end
    for (int k = 0; k < 4 && k < rx_q.size(); k++) begin
      checks++;
      if (rx_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL read_byte%0d got %h want %h", k, rx_q[k], exp_q[k]);
      end
    end
    checks++;
    if (start_q.size() != 4 || start_q[0] !== e0 + 3) begin
      errors++;
      $display("FAIL read_first_start frames=%0d first=%0d want 4 frames first %0d",
               start_q.size(), (start_q.size() > 0) ? start_q[0] : 0, e0 + 3);
    end
    for (int k = 1; k < start_q.size(); k++) begin
      checks++;
      if (start_q[k] - start_q[k-1] !== FRAME + 1) begin
        errors++;
        $display("FAIL read_gap%0d got %0d want %0d", k, start_q[k] - start_q[k-1], FRAME + 1);
      end
    end
    checks++;
    if (fall !== e0 + 3 + 4 * (FRAME + 1) - 1) begin
      errors++;
      $display("FAIL read_busy_fall got %0d want %0d", fall, e0 + 3 + 4 * (FRAME + 1) - 1);
    end
    clear_logs();
  endtask

  task automatic test_mem_select();
    logic [31:0] e0, fall;
    bit ok;
    preload(1'b0, 9'h0A7, 32'hA5A5_0001);
    preload(1'b1, 9'h0A7, 32'hFFFF_FFFF);
    exp_q = '{8'hA5, 8'hA5, 8'h00, 8'h01};
    send_pkt(1'b0, 1'b0, 9'h0A7, $urandom, e0);
    wait_idle(400, ok, fall);
    checks++;
    if (!ok || rx_q.size() != 4) begin
      errors++;
      $display("FAIL select_count idle=%b bytes=%0d want 1/4", ok, rx_q.size());
    end
    for (int k = 0; k < 4 && k < rx_q.size(); k++) begin
      checks++;
      if (rx_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL select_byte%0d got %h want %h", k, rx_q[k], exp_q[k]);
      end
    end
    clear_logs();
  endtask

  task automatic test_overrun();
    logic [31:0] e0, e1, fall;
    logic [AW-1:0] a;
    bit ok;
    a = AW'($urandom_range(0, 511));
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_before got %b want 0", overrun);
    end
    clear_logs();
    model_expect(1'b0, 1'b1, a, 32'h0);
    send_pkt(1'b0, 1'b1, a, 32'h0, e0);
    repeat (60) @(negedge clk);
    send_pkt(1'b1, 1'($urandom_range(0, 1)), a, $urandom, e1);
    wait_idle(400, ok, fall);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_flag got %b want 1", overrun);
    end
    checks++;
    if (strobe_q.size() != 1 || strobe_q[0].re !== 1'b1) begin
      errors++;
      $display("FAIL overrun_strobes count %0d want 1 read only", strobe_q.size());
    end
    checks++;
    if (rx_q.size() != 4 || fall !== e0 + 3 + 4 * (FRAME + 1) - 1) begin
      errors++;
      $display("FAIL overrun_stream bytes %0d fall %0d want 4 at %0d", rx_q.size(), fall,
               e0 + 3 + 4 * (FRAME + 1) - 1);
    end
    for (int k = 0; k < 4 && k < rx_q.size(); k++) begin
      checks++;
      if (rx_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL overrun_byte%0d got %h want %h", k, rx_q[k], exp_q[k]);
      end
    end
    clear_logs();
  endtask

  task automatic test_reset_mid_tx();
    logic [31:0] e0;
    int waited;
    clear_logs();
    send_pkt(1'b0, 1'b1, AW'($urandom_range(0, 511)), 32'h0, e0);
    waited = 0;
    while (start_q.size() < 2 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (start_q.size() < 2) begin
      errors++;
      $display("FAIL midreset_second_frame frames %0d want 2", start_q.size());
    end
    repeat (10) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({tx, busy, overrun} !== 3'b100) begin
      errors++;
      $display("FAIL midreset_state tx/busy/ovr got %b want 100", {tx, busy, overrun});
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    test_write_imem("after_reset");
  endtask

  task automatic test_back_to_back();
    logic [31:0] e0, fall;
    logic rw, typ;
    logic [AW-1:0] a;
    logic [31:0] d;
    int nb;
    bit ok;
    for (int n = 0; n < 30; n++) begin
      rw  = 1'($urandom_range(0, 1));
      typ = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       a = '0;
        1:       a = 9'h1FF;
        default: a = AW'($urandom_range(0, 511));
      endcase
      d = $urandom;
      clear_logs();
      model_expect(rw, typ, a, d);
      nb = rw ? 1 : 4;
      send_pkt(rw, typ, a, d, e0);
      wait_idle(400, ok, fall);
      checks++;
      if (!ok || strobe_q.size() != 1) begin
        errors++;
        $display("FAIL rand%0d_strobe idle=%b count=%0d want 1/1", n, ok, strobe_q.size());
      end else begin
        checks++;
        if ({strobe_q[0].i_we, strobe_q[0].d_we, strobe_q[0].re} !==
                {rw & ~typ, rw & typ, ~rw} ||
            strobe_q[0].addr !== a || strobe_q[0].cyc !== e0 ||
            (rw && strobe_q[0].wdata !== d)) begin
          errors++;
          $display("FAIL rand%0d_strobe kind %b addr %h data %h at %0d want %b %h %h at %0d",
                   n, {strobe_q[0].i_we, strobe_q[0].d_we, strobe_q[0].re}, strobe_q[0].addr,
                   strobe_q[0].wdata, strobe_q[0].cyc, {rw & ~typ, rw & typ, ~rw}, a, d, e0);
        end
      end
      checks++;
      if (rx_q.size() != nb) begin
        errors++;
        $display("FAIL rand%0d_bytes got %0d want %0d", n, rx_q.size(), nb);
      end
      for (int k = 0; k < nb && k < rx_q.size(); k++) begin
        checks++;
        if (rx_q[k] !== exp_q[k]) begin
          errors++;
          $display("FAIL rand%0d_byte%0d got %h want %h", n, k, rx_q[k], exp_q[k]);
        end
      end
      checks++;
      if (start_q.size() < 1 || start_q[0] !== e0 + (rw ? 2 : 3) ||
          fall !== e0 + (rw ? 2 : 3) + nb * (FRAME + 1) - 1) begin
        errors++;
        $display("FAIL rand%0d_timing start %0d fall %0d want %0d %0d", n,
                 (start_q.size() > 0) ? start_q[0] : 0, fall, e0 + (rw ? 2 : 3),
                 e0 + (rw ? 2 : 3) + nb * (FRAME + 1) - 1);
      end
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    reset        = 1'b1;
    pkt_valid    = 1'b0;
    pkt_data     = '0;
    pkt_addr     = '0;
    pkt_mem_type = 1'b0;
    pkt_rw       = 1'b0;
    for (int i = 0; i < 512; i++) begin
      ref_imem[i] = init_word(i, 1'b0);
      ref_dmem[i] = init_word(i, 1'b1);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_write_imem("write_imem");
    test_read_dmem();
    test_mem_select();
    test_overrun();
    test_reset_mid_tx();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
